// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a shared memory line port (I-cache = 0, D-cache = 1).
// One transaction is granted at a time; each grant ends on completion, abort or timeout.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int LINE_WIDTH = 256,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  rq0_valid,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [LINE_WIDTH-1:0] rq0_wr,
    input  logic                  rq0_rw,
    output logic [LINE_WIDTH-1:0] rq0_rd,
    output logic                  rq0_ready,

    input  logic                  rq1_valid,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [LINE_WIDTH-1:0] rq1_wr,
    input  logic                  rq1_rw,
    output logic [LINE_WIDTH-1:0] rq1_rd,
    output logic                  rq1_ready,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wr,
    output logic                  mem_rw,
    output logic                  mem_valid,
    input  logic [LINE_WIDTH-1:0] mem_rd,
    input  logic                  mem_ready,

    output logic                  err_timeout
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last_grant;
    logic            w_next_last_grant;
    logic [7:0]      r_cnt;
    logic [7:0]      w_next_cnt;

    // Currently granted requester's signals, valid only in a BUSY state
    logic                  w_sel;
    logic                  w_sel_valid;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [LINE_WIDTH-1:0] w_sel_wr;
    logic                  w_sel_rw;

    assign w_sel       = (r_state == BUSY1);
    assign w_sel_valid = w_sel ? rq1_valid : rq0_valid;
    assign w_sel_addr  = w_sel ? rq1_addr  : rq0_addr;
    assign w_sel_wr    = w_sel ? rq1_wr    : rq0_wr;
    assign w_sel_rw    = w_sel ? rq1_rw    : rq0_rw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
            r_cnt        <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_next_cnt        = r_cnt;
        mem_addr          = '0;
        mem_wr            = '0;
        mem_rw            = 1'b0;
        mem_valid         = 1'b0;
        rq0_ready         = 1'b0;
        rq0_rd            = '0;
        rq1_ready         = 1'b0;
        rq1_rd            = '0;
        err_timeout       = 1'b0;

        case (r_state)
            IDLE: begin
                w_next_cnt = 8'd0;
                // On contention the requester not served last wins
                if (rq0_valid && rq1_valid) begin
                    w_next_state = r_last_grant ? BUSY0 : BUSY1;
                end else if (rq0_valid) begin
                    w_next_state = BUSY0;
                end else if (rq1_valid) begin
                    w_next_state = BUSY1;
                end
            end

            BUSY0, BUSY1: begin
                mem_addr  = w_sel_addr;
                mem_wr    = w_sel_wr;
                mem_rw    = w_sel_rw;
                mem_valid = w_sel_valid;
                if (!w_sel_valid) begin
                    w_next_state      = IDLE;
                    w_next_last_grant = w_sel;
                end else if (mem_ready) begin
                    // Completion takes priority over a coincident timeout
                    if (w_sel) begin
                        rq1_ready = 1'b1;
                        rq1_rd    = mem_rd;
                    end else begin
                        rq0_ready = 1'b1;
                        rq0_rd    = mem_rd;
                    end
                    w_next_state      = IDLE;
                    w_next_last_grant = w_sel;
                end else if (r_cnt == TIMEOUT_CNT) begin
                    err_timeout       = 1'b1;
                    w_next_state      = IDLE;
                    w_next_last_grant = w_sel;
                end else if (r_cnt != 8'hFF) begin
                    w_next_cnt = r_cnt + 8'd1;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant/complete, write-back, timeout, abort, reset and round-robin.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int LW = 256;

    logic          clk;
    logic          rst_n;
    logic          rq0_valid, rq0_rw, rq0_ready;
    logic [AW-1:0] rq0_addr;
    logic [LW-1:0] rq0_wr, rq0_rd;
    logic          rq1_valid, rq1_rw, rq1_ready;
    logic [AW-1:0] rq1_addr;
    logic [LW-1:0] rq1_wr, rq1_rd;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wr, mem_rd;
    logic          mem_rw, mem_valid, mem_ready, err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [LW-1:0] pat_a, pat_b, pat_c;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_addr(rq0_addr), .rq0_wr(rq0_wr), .rq0_rw(rq0_rw),
        .rq0_rd(rq0_rd), .rq0_ready(rq0_ready),
        .rq1_valid(rq1_valid), .rq1_addr(rq1_addr), .rq1_wr(rq1_wr), .rq1_rw(rq1_rw),
        .rq1_rd(rq1_rd), .rq1_ready(rq1_ready),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rw(mem_rw), .mem_valid(mem_valid),
        .mem_rd(mem_rd), .mem_ready(mem_ready),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Every output must read zero outside a grant
    task automatic chk_idle(input string tag);
        chk(tag, LW'({mem_valid, mem_rw, rq0_ready, rq1_ready, err_timeout,
                      |mem_addr, |mem_wr, |rq0_rd, |rq1_rd}), '0);
    endtask

    initial begin
        pat_a = {8{32'hA5A5_0001}};
        pat_b = {8{32'hB0B0_1234}};
        pat_c = {8{32'hC3C3_5678}};

        rst_n     = 1'b0;
        rq0_addr  = 28'h0123450;
        rq0_wr    = '0;
        rq0_rw    = 1'b0;
        rq1_addr  = 28'h0ABCDE0;
        rq1_wr    = pat_b;
        rq1_rw    = 1'b1;
        rq0_valid = 1'b1;
        rq1_valid = 1'b0;
        mem_ready = 1'b1;
        mem_rd    = pat_a;

        // Reset holds everything quiet despite input activity
        smp(); chk_idle("reset_outputs");
        cyc(); rq0_valid = 1'b0; mem_ready = 1'b0; rst_n = 1'b1;
        smp(); chk_idle("post_reset");

        // rq0 fill alone, completion on 3rd BUSY cycle
        cyc(); rq0_valid = 1'b1;
        smp(); chk("t031_req_cycle_mv", LW'(mem_valid), 1'b0);
        cyc();
        smp(); chk("t031_grant_mv", LW'(mem_valid), 1'b1);
               chk("t031_addr", LW'(mem_addr), LW'(28'h0123450));
               chk("t031_rw", LW'(mem_rw), 1'b0);
        cyc();
        smp(); chk("t031_wait_rdy", LW'(rq0_ready), 1'b0);
        cyc(); mem_ready = 1'b1; mem_rd = pat_a;
        smp(); chk("t031_rdy", LW'(rq0_ready), 1'b1);
               chk("t031_rd", rq0_rd, pat_a);
               chk("t031_rq1_rdy", LW'(rq1_ready), 1'b0);
               chk("t031_err", LW'(err_timeout), 1'b0);
        cyc(); rq0_valid = 1'b0;
        smp(); chk_idle("t031_idle_ignores_ready");

        // rq1 write-back
        cyc(); mem_ready = 1'b0; rq1_valid = 1'b1;
        smp(); chk("t033_req_cycle_mv", LW'(mem_valid), 1'b0);
        cyc();
        smp(); chk("t033_mv", LW'(mem_valid), 1'b1);
               chk("t033_rw", LW'(mem_rw), 1'b1);
               chk("t033_wr", mem_wr, pat_b);
               chk("t033_addr", LW'(mem_addr), LW'(28'h0ABCDE0));
        cyc(); mem_rd = pat_c; mem_ready = 1'b1;
        smp(); chk("t033_rw2", LW'(mem_rw), 1'b1);
               chk("t033_wr2", mem_wr, pat_b);
               chk("t033_addr2", LW'(mem_addr), LW'(28'h0ABCDE0));
               chk("t033_rdy", LW'(rq1_ready), 1'b1);
               chk("t033_rd", rq1_rd, pat_c);
               chk("t033_rq0_rdy", LW'(rq0_ready), 1'b0);
               chk("t033_rq0_rd", rq0_rd, '0);
        cyc(); rq1_valid = 1'b0; mem_ready = 1'b0;
        smp(); chk_idle("t033_after");

        // Timeout with TIMEOUT=4: error on 5th BUSY cycle
        cyc(); rq0_valid = 1'b1;
        smp();
        for (int i = 1; i <= 4; i++) begin
            cyc();
            smp(); chk($sformatf("t034_no_err_c%0d", i), LW'(err_timeout), 1'b0);
        end
        cyc();
        smp(); chk("t034_err", LW'(err_timeout), 1'b1);
               chk("t034_no_rdy", LW'(rq0_ready), 1'b0);
        cyc();
        smp(); chk("t034_idle_mv", LW'(mem_valid), 1'b0);
               chk("t034_idle_err", LW'(err_timeout), 1'b0);

        // Re-grant; completion coinciding with the timeout cycle wins
        for (int i = 1; i <= 4; i++) begin
            cyc();
            smp();
        end
        cyc(); mem_ready = 1'b1; mem_rd = pat_a;
        smp(); chk("t028_rdy", LW'(rq0_ready), 1'b1);
               chk("t028_err", LW'(err_timeout), 1'b0);
        cyc(); rq0_valid = 1'b0; mem_ready = 1'b0;
        smp(); chk_idle("t028_after");

        // rq0 aborts in 2nd BUSY cycle while rq1 waits
        cyc(); rq0_valid = 1'b1;
        smp();
        cyc(); rq1_valid = 1'b1;
        smp(); chk("t035_mv", LW'(mem_valid), 1'b1);
               chk("t035_addr", LW'(mem_addr), LW'(28'h0123450));
        cyc(); rq0_valid = 1'b0; mem_ready = 1'b1;
        smp(); chk("t035_abort_mv", LW'(mem_valid), 1'b0);
               chk("t035_abort_rdy0", LW'(rq0_ready), 1'b0);
               chk("t035_abort_rdy1", LW'(rq1_ready), 1'b0);
               chk("t035_abort_err", LW'(err_timeout), 1'b0);
        cyc(); mem_ready = 1'b0;
        smp(); chk("t035_gap_mv", LW'(mem_valid), 1'b0);
        cyc();
        smp(); chk("t035_rq1_mv", LW'(mem_valid), 1'b1);
               chk("t035_rq1_addr", LW'(mem_addr), LW'(28'h0ABCDE0));

        // Asynchronous reset mid-BUSY1
        #1 rst_n = 1'b0;
        #1 chk_idle("t036_async_reset");
        rq0_valid = 1'b1;
        cyc();
        smp(); chk_idle("t036_in_reset");
        cyc(); rst_n = 1'b1;
        smp(); chk_idle("t036_release");

        // Both requesters keep requesting: 0,1,0,1 with an IDLE cycle between grants
        for (int g = 0; g < 4; g++) begin
            cyc();
            smp(); chk($sformatf("t032_mv_g%0d", g), LW'(mem_valid), 1'b1);
                   chk($sformatf("t032_addr_g%0d", g), LW'(mem_addr),
                       LW'((g % 2) ? 28'h0ABCDE0 : 28'h0123450));
            cyc(); mem_ready = 1'b1; mem_rd = (g % 2) ? pat_c : pat_a;
            smp(); chk($sformatf("t032_rdy0_g%0d", g), LW'(rq0_ready), LW'((g % 2) == 0));
                   chk($sformatf("t032_rdy1_g%0d", g), LW'(rq1_ready), LW'((g % 2) == 1));
            cyc(); mem_ready = 1'b0;
            smp(); chk($sformatf("t032_gap_g%0d", g), LW'(mem_valid), 1'b0);
        end

        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
